// File: rtl/muldiv_unit.sv
// RV32M multiply/divide unit: registered multiply, 32-step restoring divider,
// one-cycle fast path for divide-by-zero and signed overflow.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] op_a_i,
    input  logic [XLEN-1:0] op_b_i,
    input  logic [4:0]      rd_i,
    input  logic            flush_i,
    output logic            ready_o,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o,
    output logic [4:0]      rd_o
);
    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

    state_t            r_state;
    state_t            w_next;
    logic [2:0]        r_funct3;
    logic [XLEN-1:0]   r_a, r_b, r_quo, r_rem, r_div, r_result;
    logic              r_sa, r_sb, r_neg_q, r_neg_r;
    logic [4:0]        r_tag, r_rd, r_cnt;

    logic              w_accept, w_is_div, w_div_signed, w_sa, w_sb;
    logic              w_b_zero, w_ovf, w_fast, w_load_res;
    logic [XLEN-1:0]   w_mag_a, w_mag_b, w_fast_res, w_mul_res, w_fix_res, w_new_res;
    logic [63:0]       w_a64, w_b64, w_prod;
    logic [XLEN:0]     w_rem_sh, w_sub;
    logic              w_ge, w_unused;

    // Operand decode at accept time.
    assign w_accept     = (r_state == S_IDLE) && start_i && !flush_i;
    assign w_is_div     = funct3_i[2];
    assign w_div_signed = !funct3_i[0];
    assign w_sa         = w_is_div ? w_div_signed : (funct3_i[1:0] != 2'b11);
    assign w_sb         = w_is_div ? w_div_signed : !funct3_i[1];
    assign w_b_zero     = (op_b_i == '0);
    assign w_ovf        = w_div_signed && (op_a_i == 32'h8000_0000) && (op_b_i == 32'hFFFF_FFFF);
    assign w_fast       = w_is_div && (w_b_zero || w_ovf);
    assign w_mag_a      = (w_sa && op_a_i[XLEN-1]) ? -op_a_i : op_a_i;
    assign w_mag_b      = (w_sb && op_b_i[XLEN-1]) ? -op_b_i : op_b_i;

    always_comb begin
        w_fast_res = '0;
        if (funct3_i[1])
            w_fast_res = w_b_zero ? op_a_i : '0;
        else
            w_fast_res = w_b_zero ? 32'hFFFF_FFFF : 32'h8000_0000;
    end

    // Sign-extending to 64 bits gives the low half of the 33x33 signed product.
    assign w_a64     = {{32{r_sa & r_a[XLEN-1]}}, r_a};
    assign w_b64     = {{32{r_sb & r_b[XLEN-1]}}, r_b};
    assign w_prod    = w_a64 * w_b64;
    assign w_mul_res = (r_funct3[1:0] == 2'b00) ? w_prod[31:0] : w_prod[63:32];

    // Remainder stays below the divisor, so the top bit of each step is spare.
    assign w_rem_sh  = {r_rem, r_quo[XLEN-1]};
    assign w_ge      = (w_rem_sh >= {1'b0, r_div});
    assign w_sub     = w_rem_sh - {1'b0, r_div};
    assign w_unused  = w_sub[XLEN] | w_rem_sh[XLEN];

    assign w_fix_res = r_funct3[1] ? (r_neg_r ? -r_rem : r_rem)
                                   : (r_neg_q ? -r_quo : r_quo);

    always_comb begin
        w_new_res = w_fix_res;
        case (r_state)
            S_IDLE:  w_new_res = w_fast_res;
            S_MUL:   w_new_res = w_mul_res;
            default: w_new_res = w_fix_res;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_next = w_fast ? S_DONE : (w_is_div ? S_DIV : S_MUL);
            S_MUL:  w_next = flush_i ? S_IDLE : S_DONE;
            S_DIV:  w_next = flush_i ? S_IDLE : ((r_cnt == 5'd0) ? S_FIX : S_DIV);
            S_FIX:  w_next = flush_i ? S_IDLE : S_DONE;
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    assign w_load_res = (w_next == S_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_funct3 <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_sa     <= 1'b0;
            r_sb     <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_quo    <= '0;
            r_rem    <= '0;
            r_div    <= '0;
            r_cnt    <= '0;
            r_tag    <= '0;
            r_rd     <= '0;
            r_result <= '0;
        end else begin
            if (w_accept) begin
                r_funct3 <= funct3_i;
                r_a      <= op_a_i;
                r_b      <= op_b_i;
                r_sa     <= w_sa;
                r_sb     <= w_sb;
                r_neg_q  <= w_div_signed && (op_a_i[XLEN-1] ^ op_b_i[XLEN-1]);
                r_neg_r  <= w_div_signed && op_a_i[XLEN-1];
                r_quo    <= w_mag_a;
                r_rem    <= '0;
                r_div    <= w_mag_b;
                r_cnt    <= 5'd31;
                r_tag    <= rd_i;
            end
            if (r_state == S_DIV) begin
                r_rem <= w_ge ? w_sub[XLEN-1:0] : w_rem_sh[XLEN-1:0];
                r_quo <= {r_quo[XLEN-2:0], w_ge};
                if (r_cnt != 5'd0) r_cnt <= r_cnt - 5'd1;
            end
            if (w_load_res) begin
                r_result <= w_new_res;
                r_rd     <= (r_state == S_IDLE) ? rd_i : r_tag;
            end
        end
    end

    assign ready_o  = (r_state == S_IDLE);
    assign busy_o   = (r_state == S_MUL) || (r_state == S_DIV) || (r_state == S_FIX);
    assign done_o   = (r_state == S_DONE);
    assign result_o = r_result;
    assign rd_o     = r_rd;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: vector table plus flush, reset and
// start-while-busy sequences.
module tb_muldiv_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_i;
  logic [2:0]  funct3_i;
  logic [31:0] op_a_i, op_b_i;
  logic [4:0]  rd_i;
  logic        flush_i;
  logic        ready_o, busy_o, done_o;
  logic [31:0] result_o;
  logic [4:0]  rd_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
    int          lat;
    int          busy;
  } vec_t;

  vec_t vecs[22];

  muldiv_unit dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (start_i),
    .funct3_i (funct3_i),
    .op_a_i   (op_a_i),
    .op_b_i   (op_b_i),
    .rd_i     (rd_i),
    .flush_i  (flush_i),
    .ready_o  (ready_o),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .result_o (result_o),
    .rd_o     (rd_o)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Accept one op, scramble the inputs afterwards, wait for done_o.
  task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, output int lat, output logic [31:0] res,
                       output logic [4:0] rdo, output int busy_cnt);
    @(negedge clk);
    start_i = 1'b1; funct3_i = f; op_a_i = a; op_b_i = b; rd_i = rd;
    @(posedge clk); #1;
    start_i = 1'b0;
    funct3_i = 3'($urandom_range(0, 7));
    op_a_i = $urandom; op_b_i = $urandom;
    rd_i = 5'($urandom_range(0, 31));
    lat = -1; busy_cnt = 0; res = 'x; rdo = 'x;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (busy_o) busy_cnt++;
      if (done_o) begin
        lat = k; res = result_o; rdo = rd_o;
        break;
      end
    end
  endtask

  initial begin
    int lat, busy_cnt, seen_done;
    logic [31:0] res, last_res;
    logic [4:0]  rdo;

    vecs[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 5'd1,  32'hFFFF_FFEB, 2,  1};
    vecs[1]  = '{3'd1, 32'h8000_0000, 32'h8000_0000, 5'd2,  32'h4000_0000, 2,  1};
    vecs[2]  = '{3'd3, 32'h8000_0000, 32'h8000_0000, 5'd3,  32'h4000_0000, 2,  1};
    vecs[3]  = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4,  32'hFFFF_FFFF, 2,  1};
    vecs[4]  = '{3'd4, 32'hFFFF_FFF9, 32'd2,          5'd5,  32'hFFFF_FFFD, 34, 33};
    vecs[5]  = '{3'd6, 32'hFFFF_FFF9, 32'd2,          5'd6,  32'hFFFF_FFFF, 34, 33};
    vecs[6]  = '{3'd5, 32'd100,        32'd7,          5'd7,  32'd14,        34, 33};
    vecs[7]  = '{3'd7, 32'd100,        32'd7,          5'd8,  32'd2,         34, 33};
    vecs[8]  = '{3'd5, 32'd5,          32'd0,          5'd9,  32'hFFFF_FFFF, 1,  0};
    vecs[9]  = '{3'd7, 32'd5,          32'd0,          5'd10, 32'd5,         1,  0};
    vecs[10] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000, 1,  0};
    vecs[11] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'd0,         1,  0};
    vecs[12] = '{3'd0, 32'h1234_5678, 32'h10,         5'd13, 32'h2345_6780, 2,  1};
    vecs[13] = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd14, 32'hFFFF_FFFE, 2,  1};
    vecs[14] = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd15, 32'd0,         2,  1};
    vecs[15] = '{3'd4, 32'd7,          32'hFFFF_FFFE, 5'd16, 32'hFFFF_FFFD, 34, 33};
    vecs[16] = '{3'd6, 32'd7,          32'hFFFF_FFFE, 5'd17, 32'd1,         34, 33};
    vecs[17] = '{3'd4, 32'd0,          32'd0,          5'd18, 32'hFFFF_FFFF, 1,  0};
    vecs[18] = '{3'd6, 32'hFFFF_FFF9, 32'd0,          5'd19, 32'hFFFF_FFF9, 1,  0};
    vecs[19] = '{3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 5'd20, 32'd0,         34, 33};
    vecs[20] = '{3'd4, 32'h8000_0000, 32'd1,          5'd21, 32'h8000_0000, 34, 33};
    vecs[21] = '{3'd7, 32'hFFFF_FFFF, 32'd16,         5'd22, 32'd15,        34, 33};

    // reset
    rst_n = 1'b0; start_i = 1'b0; flush_i = 1'b0;
    funct3_i = '0; op_a_i = '0; op_b_i = '0; rd_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(ready_o), 32'd1);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_result", result_o, 32'd0);
    check("rst_rd", 32'(rd_o), 32'd0);
    rst_n = 1'b1;

    // vector table
    for (int i = 0; i < 22; i++) begin
      do_op(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].rd, lat, res, rdo, busy_cnt);
      check($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      check($sformatf("v%0d_busy_cycles", i), 32'(busy_cnt), 32'(vecs[i].busy));
      check($sformatf("v%0d_result", i), res, vecs[i].exp);
      check($sformatf("v%0d_rd", i), 32'(rdo), 32'(vecs[i].rd));
    end
    last_res = vecs[21].exp;

    // result held through idle
    repeat (3) @(negedge clk);
    check("hold_result", result_o, last_res);
    check("hold_done", 32'(done_o), 32'd0);

    // flush_i in IDLE blocks accept
    @(negedge clk);
    start_i = 1'b1; flush_i = 1'b1; funct3_i = 3'd0; op_a_i = 32'd2; op_b_i = 32'd2;
    @(posedge clk); #1;
    start_i = 1'b0; flush_i = 1'b0;
    @(negedge clk);
    check("idle_flush_ready", 32'(ready_o), 32'd1);
    check("idle_flush_busy", 32'(busy_o), 32'd0);

    // flush DIV at cycle 10, then MUL 3x4 accepted at cycle 11
    @(negedge clk);
    start_i = 1'b1; funct3_i = 3'd4; op_a_i = 32'd1000; op_b_i = 32'd3; rd_i = 5'd25;
    @(posedge clk); #1;
    start_i = 1'b0;
    seen_done = 0;
    repeat (9) begin
      @(negedge clk);
      if (done_o) seen_done = 1;
      @(posedge clk); #1;
    end
    flush_i = 1'b1;
    @(negedge clk);
    if (done_o) seen_done = 1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    start_i = 1'b1; funct3_i = 3'd0; op_a_i = 32'd3; op_b_i = 32'd4; rd_i = 5'd26;
    @(negedge clk);
    check("flush_no_done", 32'(seen_done | done_o), 32'd0);
    check("flush_ready_c11", 32'(ready_o), 32'd1);
    check("flush_result_kept", result_o, last_res);
    @(posedge clk); #1;
    start_i = 1'b0;
    @(negedge clk);
    check("post_flush_busy_c12", 32'(busy_o), 32'd1);
    check("post_flush_done_c12", 32'(done_o), 32'd0);
    @(negedge clk);
    check("post_flush_done_c13", 32'(done_o), 32'd1);
    check("post_flush_result", result_o, 32'd12);
    check("post_flush_rd", 32'(rd_o), 32'd26);

    // start_i held during busy and DONE is ignored
    @(negedge clk);
    start_i = 1'b1; funct3_i = 3'd5; op_a_i = 32'd100; op_b_i = 32'd7; rd_i = 5'd3;
    @(posedge clk); #1;
    funct3_i = 3'd0; op_a_i = 32'd3; op_b_i = 32'd4; rd_i = 5'd7;
    lat = -1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (done_o) begin lat = k; break; end
    end
    check("busy_start_latency", 32'(lat), 32'd34);
    check("busy_start_result", result_o, 32'd14);
    check("busy_start_rd", 32'(rd_o), 32'd3);
    @(posedge clk); #1;
    start_i = 1'b0;
    @(negedge clk);
    check("done_one_cycle", 32'(done_o), 32'd0);
    check("after_done_ready", 32'(ready_o), 32'd1);
    @(negedge clk);
    check("after_done_busy", 32'(busy_o), 32'd0);
    check("after_done_result", result_o, 32'd14);

    // asynchronous reset during a DIV
    @(negedge clk);
    start_i = 1'b1; funct3_i = 3'd4; op_a_i = 32'd500; op_b_i = 32'd5; rd_i = 5'd30;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_ready", 32'(ready_o), 32'd1);
    check("arst_busy", 32'(busy_o), 32'd0);
    check("arst_done", 32'(done_o), 32'd0);
    check("arst_result", result_o, 32'd0);
    check("arst_rd", 32'(rd_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(3'd4, 32'd7, 32'hFFFF_FFFE, 5'd4, lat, res, rdo, busy_cnt);
    check("recover_latency", 32'(lat), 32'd34);
    check("recover_result", res, 32'hFFFF_FFFD);
    check("recover_rd", 32'(rdo), 32'd4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
